// File: rtl/battleship_pkg.sv
// Shared types and defaults for the battleship shot responder.
package battleship_pkg;

    localparam int BOARD_SIZE_DEFAULT = 5;
    localparam int MAX_BOATS_DEFAULT  = 5;

    typedef logic [2:0] coord_t;

    typedef enum logic [2:0] {
        SETUP = 3'd0,
        READY = 3'd1,
        CHECK = 3'd2,
        RESP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // True when both coordinates fall inside a size x size board.
    function automatic logic coordInRange(input coord_t row, input coord_t col, input int size);
        return (int'(row) < size) && (int'(col) < size);
    endfunction

endpackage

// File: rtl/cell_grid.sv
// N x N single-bit cell store: set-only synchronous write, combinational read,
// synchronous clear that overrides any write on the same edge.
module cell_grid
    import battleship_pkg::*;
#(
    parameter int N = BOARD_SIZE_DEFAULT
) (
    input  logic       clk,
    input  logic       clr_i,
    input  logic       we_i,
    input  logic [2:0] wr_row_i,
    input  logic [2:0] wr_col_i,
    input  logic [2:0] rd_row_i,
    input  logic [2:0] rd_col_i,
    output logic       rd_data_o
);

    localparam int CELLS = N * N;
    localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;

    logic [CELLS-1:0] cells_q;
    logic [IW-1:0]    wrIdx;
    logic [IW-1:0]    rdIdx;
    logic             wrInRange;
    logic             rdInRange;

    assign wrInRange = coordInRange(wr_row_i, wr_col_i, N);
    assign rdInRange = coordInRange(rd_row_i, rd_col_i, N);
    assign wrIdx     = IW'(int'(wr_row_i) * N + int'(wr_col_i));
    assign rdIdx     = IW'(int'(rd_row_i) * N + int'(rd_col_i));

    // Out-of-range reads report an empty cell so callers never see a stray bit.
    assign rd_data_o = rdInRange ? cells_q[rdIdx] : 1'b0;

    // Cells only ever get set during play; clearing is the sole way back to empty.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            cells_q <= '0;
        end else if (we_i && wrInRange) begin
            cells_q[wrIdx] <= 1'b1;
        end
    end

endmodule

// File: rtl/shot_responder.sv
// Battleship defender: accepts boat placements during setup, then answers
// each incoming shot with a hit / repeat / invalid result two cycles later.
module shot_responder
    import battleship_pkg::*;
#(
    parameter int BOARD_SIZE = BOARD_SIZE_DEFAULT,
    parameter int MAX_BOATS  = MAX_BOATS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       place_en,
    input  logic [2:0] place_row,
    input  logic [2:0] place_col,
    input  logic       start,
    input  logic       shot_valid,
    input  logic [2:0] shot_row,
    input  logic [2:0] shot_col,
    output logic       shot_ready,
    output logic       resp_valid,
    output logic       resp_hit,
    output logic       resp_repeat,
    output logic       resp_invalid,
    output logic [2:0] boats_left,
    output logic       all_sunk
);

    localparam logic [2:0] MAX_BOATS_C = 3'(MAX_BOATS);

    state_t     state_q;
    coord_t     shotRow_q;
    coord_t     shotCol_q;
    logic [2:0] boatsLeft_q;
    logic       shotReady_q;
    logic       respValid_q;
    logic       respHit_q;
    logic       respRepeat_q;
    logic       respInvalid_q;
    logic       allSunk_q;

    logic       gridClr;
    coord_t     occRdRow;
    coord_t     occRdCol;
    logic       occRd;
    logic       shotRd;
    logic       placeInRange;
    logic       placeOk;
    logic       startOk;
    logic       shotInRange;
    logic       shotMark_d;
    logic [2:0] boatsAfterPlace_d;
    logic [2:0] boatsAfterShot_d;

    assign gridClr = !rst;

    // The occupancy grid is probed at the placement coords during setup and at
    // the latched shot coords otherwise, so one read port serves both phases.
    assign occRdRow = (state_q == SETUP) ? place_row : shotRow_q;
    assign occRdCol = (state_q == SETUP) ? place_col : shotCol_q;

    assign placeInRange = coordInRange(place_row, place_col, BOARD_SIZE);
    assign placeOk      = (state_q == SETUP) && place_en && placeInRange
                          && !occRd && (boatsLeft_q < MAX_BOATS_C);
    assign boatsAfterPlace_d = placeOk ? (boatsLeft_q + 3'd1) : boatsLeft_q;

    // Start is judged against the count that includes a same-cycle placement.
    assign startOk = (state_q == SETUP) && start && (boatsAfterPlace_d != 3'd0);

    assign shotInRange = coordInRange(shotRow_q, shotCol_q, BOARD_SIZE);
    assign shotMark_d  = (state_q == CHECK) && shotInRange && !shotRd;
    assign boatsAfterShot_d = (shotMark_d && occRd && (boatsLeft_q != 3'd0))
                              ? (boatsLeft_q - 3'd1) : boatsLeft_q;

    cell_grid #(.N(BOARD_SIZE)) u_occupancy (
        .clk      (clk),
        .clr_i    (gridClr),
        .we_i     (placeOk),
        .wr_row_i (place_row),
        .wr_col_i (place_col),
        .rd_row_i (occRdRow),
        .rd_col_i (occRdCol),
        .rd_data_o(occRd)
    );

    cell_grid #(.N(BOARD_SIZE)) u_shot_history (
        .clk      (clk),
        .clr_i    (gridClr),
        .we_i     (shotMark_d),
        .wr_row_i (shotRow_q),
        .wr_col_i (shotCol_q),
        .rd_row_i (shotRow_q),
        .rd_col_i (shotCol_q),
        .rd_data_o(shotRd)
    );

    // Game FSM with all handshake and result outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= SETUP;
            shotRow_q     <= '0;
            shotCol_q     <= '0;
            boatsLeft_q   <= '0;
            shotReady_q   <= 1'b0;
            respValid_q   <= 1'b0;
            respHit_q     <= 1'b0;
            respRepeat_q  <= 1'b0;
            respInvalid_q <= 1'b0;
            allSunk_q     <= 1'b0;
        end else begin
            case (state_q)
                SETUP: begin
                    boatsLeft_q <= boatsAfterPlace_d;
                    if (startOk) begin
                        state_q     <= READY;
                        shotReady_q <= 1'b1;
                    end
                end
                READY: begin
                    if (shot_valid && shotReady_q) begin
                        shotRow_q   <= shot_row;
                        shotCol_q   <= shot_col;
                        shotReady_q <= 1'b0;
                        state_q     <= CHECK;
                    end
                end
                CHECK: begin
                    state_q       <= RESP;
                    respValid_q   <= 1'b1;
                    respInvalid_q <= !shotInRange;
                    respRepeat_q  <= shotInRange && shotRd;
                    respHit_q     <= shotInRange && occRd;
                    boatsLeft_q   <= boatsAfterShot_d;
                end
                RESP: begin
                    respValid_q   <= 1'b0;
                    respHit_q     <= 1'b0;
                    respRepeat_q  <= 1'b0;
                    respInvalid_q <= 1'b0;
                    if (boatsLeft_q == 3'd0) begin
                        state_q   <= DONE;
                        allSunk_q <= 1'b1;
                    end else begin
                        state_q     <= READY;
                        shotReady_q <= 1'b1;
                    end
                end
                DONE: begin
                end
                default: begin
                    state_q <= SETUP;
                end
            endcase
        end
    end

    assign shot_ready   = shotReady_q;
    assign resp_valid   = respValid_q;
    assign resp_hit     = respHit_q;
    assign resp_repeat  = respRepeat_q;
    assign resp_invalid = respInvalid_q;
    assign boats_left   = boatsLeft_q;
    assign all_sunk     = allSunk_q;

endmodule

// File: tb/tb_shot_responder.sv
// Directed bench for shot_responder: a table of operations with hand-computed
// results, plus a hand-written reset-during-CHECK sequence.
`timescale 1ns/1ps
module tb_shot_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       place_en;
    logic [2:0] place_row;
    logic [2:0] place_col;
    logic       start;
    logic       shot_valid;
    logic [2:0] shot_row;
    logic [2:0] shot_col;
    logic       shot_ready;
    logic       resp_valid;
    logic       resp_hit;
    logic       resp_repeat;
    logic       resp_invalid;
    logic [2:0] boats_left;
    logic       all_sunk;

    int assertCount = 0;
    int failCount   = 0;

    // 10 ns clock
    always #5 clk = ~clk;

    shot_responder #(.BOARD_SIZE(5), .MAX_BOATS(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .place_en    (place_en),
        .place_row   (place_row),
        .place_col   (place_col),
        .start       (start),
        .shot_valid  (shot_valid),
        .shot_row    (shot_row),
        .shot_col    (shot_col),
        .shot_ready  (shot_ready),
        .resp_valid  (resp_valid),
        .resp_hit    (resp_hit),
        .resp_repeat (resp_repeat),
        .resp_invalid(resp_invalid),
        .boats_left  (boats_left),
        .all_sunk    (all_sunk)
    );

    typedef enum int {OP_RESET, OP_PLACE, OP_START, OP_PLACE_START, OP_SHOT, OP_BLOCKED} op_t;

    typedef struct {
        op_t        op;
        logic [2:0] row;
        logic [2:0] col;
        logic       expHit;
        logic       expRepeat;
        logic       expInvalid;
        logic [2:0] expBoats;
        logic       expReady;
        logic       expSunk;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(op_t op, int row, int col, int hit, int rep, int inv,
                                   int boats, int ready, int sunk);
        vec_t v;
        v.op         = op;
        v.row        = 3'(row);
        v.col        = 3'(col);
        v.expHit     = 1'(hit);
        v.expRepeat  = 1'(rep);
        v.expInvalid = 1'(inv);
        v.expBoats   = 3'(boats);
        v.expReady   = 1'(ready);
        v.expSunk    = 1'(sunk);
        return v;
    endfunction

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives one shot and checks the response lands exactly two edges after accept.
    task automatic doShot(input vec_t v, input string tag);
        int waitCycles;
        waitCycles = 0;
        shot_row   = v.row;
        shot_col   = v.col;
        shot_valid = 1'b1;
        while (!shot_ready && waitCycles < 10) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!shot_ready) begin
            shot_valid = 1'b0;
            checkOutput({tag, " shot_ready_timeout"}, int'(shot_ready), 1);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        shot_valid = 1'b0;
        checkOutput({tag, " resp_valid_cycle1"}, int'(resp_valid), 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, " resp_valid_cycle2"}, int'(resp_valid), 1);
        checkOutput({tag, " resp_hit"}, int'(resp_hit), int'(v.expHit));
        checkOutput({tag, " resp_repeat"}, int'(resp_repeat), int'(v.expRepeat));
        checkOutput({tag, " resp_invalid"}, int'(resp_invalid), int'(v.expInvalid));
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, " resp_valid_cycle3"}, int'(resp_valid), 0);
    endtask

    // Executes one table entry starting and ending on a falling edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        int    sawResp;
        tag = $sformatf("vec%0d", idx);
        case (v.op)
            OP_RESET: begin
                rst = 1'b0;
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                checkOutput({tag, " rst resp_valid"}, int'(resp_valid), 0);
                checkOutput({tag, " rst resp_flags"},
                            int'({resp_hit, resp_repeat, resp_invalid}), 0);
                rst = 1'b1;
            end
            OP_PLACE, OP_START, OP_PLACE_START: begin
                place_en  = (v.op != OP_START);
                start     = (v.op != OP_PLACE);
                place_row = v.row;
                place_col = v.col;
                @(posedge clk);
                @(negedge clk);
                place_en = 1'b0;
                start    = 1'b0;
            end
            OP_SHOT: begin
                doShot(v, tag);
            end
            OP_BLOCKED: begin
                sawResp    = 0;
                shot_row   = v.row;
                shot_col   = v.col;
                shot_valid = 1'b1;
                repeat (6) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (resp_valid) sawResp = 1;
                end
                shot_valid = 1'b0;
                checkOutput({tag, " no_response"}, sawResp, 0);
            end
            default: begin
            end
        endcase
        checkOutput({tag, " boats_left"}, int'(boats_left), int'(v.expBoats));
        checkOutput({tag, " shot_ready"}, int'(shot_ready), int'(v.expReady));
        checkOutput({tag, " all_sunk"}, int'(all_sunk), int'(v.expSunk));
    endtask

    // Safety net so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test: table first, then the reset-during-CHECK sequence.
    initial begin
        int sawResp;
        rst        = 1'b0;
        place_en   = 1'b0;
        place_row  = '0;
        place_col  = '0;
        start      = 1'b0;
        shot_valid = 1'b0;
        shot_row   = '0;
        shot_col   = '0;

        //                  op              r  c  hit rep inv boats rdy sunk
        vecs.push_back(mkVec(OP_RESET,      0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(OP_START,      0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(OP_PLACE,      1, 2, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mkVec(OP_PLACE,      1, 2, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mkVec(OP_PLACE,      5, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mkVec(OP_PLACE,      3, 4, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mkVec(OP_PLACE,      0, 7, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mkVec(OP_START,      0, 0, 0, 0, 0, 2, 1, 0));
        vecs.push_back(mkVec(OP_PLACE,      0, 0, 0, 0, 0, 2, 1, 0));
        vecs.push_back(mkVec(OP_SHOT,       1, 2, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mkVec(OP_SHOT,       0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mkVec(OP_SHOT,       0, 0, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mkVec(OP_SHOT,       6, 1, 0, 0, 1, 1, 1, 0));
        vecs.push_back(mkVec(OP_SHOT,       1, 2, 1, 1, 0, 1, 1, 0));
        vecs.push_back(mkVec(OP_SHOT,       2, 7, 0, 0, 1, 1, 1, 0));
        vecs.push_back(mkVec(OP_SHOT,       3, 4, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mkVec(OP_BLOCKED,    3, 4, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mkVec(OP_PLACE,      0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mkVec(OP_START,      0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mkVec(OP_RESET,      0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(OP_PLACE_START,4, 4, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mkVec(OP_SHOT,       4, 4, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mkVec(OP_BLOCKED,    4, 4, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mkVec(OP_RESET,      0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(OP_PLACE_START,5, 5, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(OP_BLOCKED,    0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec(OP_PLACE,      0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mkVec(OP_PLACE,      0, 1, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mkVec(OP_PLACE,      4, 4, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mkVec(OP_PLACE,      4, 0, 0, 0, 0, 4, 0, 0));
        vecs.push_back(mkVec(OP_PLACE,      0, 4, 0, 0, 0, 5, 0, 0));
        vecs.push_back(mkVec(OP_PLACE,      2, 2, 0, 0, 0, 5, 0, 0));
        vecs.push_back(mkVec(OP_START,      0, 0, 0, 0, 0, 5, 1, 0));
        vecs.push_back(mkVec(OP_SHOT,       1, 2, 0, 0, 0, 5, 1, 0));
        vecs.push_back(mkVec(OP_SHOT,       4, 4, 1, 0, 0, 4, 1, 0));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // Reset lands while the accepted shot sits in CHECK: no response may follow.
        shot_row   = 3'd0;
        shot_col   = 3'd0;
        shot_valid = 1'b1;
        checkOutput("rstchk ready_before_accept", int'(shot_ready), 1);
        @(posedge clk);
        @(negedge clk);
        shot_valid = 1'b0;
        rst        = 1'b0;
        checkOutput("rstchk resp_valid_in_check", int'(resp_valid), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        checkOutput("rstchk resp_valid_after_rst", int'(resp_valid), 0);
        checkOutput("rstchk boats_left", int'(boats_left), 0);
        checkOutput("rstchk shot_ready", int'(shot_ready), 0);
        checkOutput("rstchk all_sunk", int'(all_sunk), 0);
        sawResp = 0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (resp_valid) sawResp = 1;
        end
        checkOutput("rstchk no_late_response", sawResp, 0);
        applyStimulus(mkVec(OP_START, 0, 0, 0, 0, 0, 0, 0, 0), 100);
        applyStimulus(mkVec(OP_PLACE, 0, 0, 0, 0, 0, 1, 0, 0), 101);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
